// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its clients
// (MEM unit and sprite/OAM DMA engine).
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   owner_e                 : read-return owner tag (OWN_CPU = 0, OWN_DMA = 1)
//   cnt_width()             : width needed to hold a counter value 0..lim
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Never returns less than 1 so a zero limit still yields a legal vector.
  function automatic int cnt_width(input int lim);
    int w;
    w = $clog2(lim + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the shared synchronous
// data memory and the arbiter.
//   cpu_* : CPU MEM-stage request/payload in, grant/stall/read-return out
//   dma_* : DMA request/payload in, grant/read-return out
//   mem_* : memory port (enable, write strobe, address, wdata out; rdata in)
// Modports:
//   master : requester/memory side (drives requests and mem_rdata)
//   slave  : arbiter side
interface dmem_arbiter_if
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_grant;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_grant, cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_grant, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_grant, cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_grant, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared single-port data memory.
// CPU has priority; a DMA request denied STARVE_LIM consecutive cycles wins
// the next cycle. Grants are combinational, so one access can issue every
// cycle. Read data returns one cycle after the grant and is steered to the
// requester recorded in the owner tag; each requester's rdata holds its last
// returned word between returns.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : dmem_arbiter_if.slave (CPU, DMA and memory signals)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            rst,
  dmem_arbiter_if.slave   bus
);

  localparam int CNT_W = cnt_width(STARVE_LIM);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_win, dma_win, any_win, win_we;
  logic dma_starved, rd_vld, cpu_ret, dma_ret;

  // Arbitration: everything is gated by rst so a request present while in
  // reset can neither touch memory nor leave a pending read behind.
  always_comb begin
    dma_starved = (starve_cnt_q == CNT_LIM);
    dma_win     = ~rst & bus.dma_req & (~bus.cpu_req | dma_starved);
    cpu_win     = ~rst & bus.cpu_req & ~dma_win;
    any_win     = cpu_win | dma_win;
    win_we      = dma_win ? bus.dma_we : bus.cpu_we;
  end

  assign bus.cpu_grant = cpu_win;
  assign bus.dma_grant = dma_win;
  assign bus.cpu_stall = ~rst & bus.cpu_req & ~cpu_win;

  assign bus.mem_en    = any_win;
  assign bus.mem_we    = any_win & win_we;
  assign bus.mem_addr  = dma_win ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata = dma_win ? bus.dma_wdata : bus.cpu_wdata;

  // Read return: the pending flag is masked by rst so a read issued just
  // before reset never reports valid data.
  always_comb begin
    rd_vld  = rd_pend_q & ~rst;
    cpu_ret = rd_vld & (owner_q == OWN_CPU);
    dma_ret = rd_vld & (owner_q == OWN_DMA);
  end

  assign bus.cpu_rvalid = cpu_ret;
  assign bus.dma_rvalid = dma_ret;
  assign bus.cpu_rdata  = cpu_ret ? bus.mem_rdata : cpu_rdata_q;
  assign bus.dma_rdata  = dma_ret ? bus.mem_rdata : dma_rdata_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = any_win & ~win_we;
    owner_d      = owner_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;

    if (dma_win) begin
      starve_cnt_d = '0;
    end else if (bus.dma_req && !dma_starved) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    // The tag only moves on a read grant; writes leave it untouched.
    if (any_win && !win_we) begin
      owner_d = dma_win ? OWN_DMA : OWN_CPU;
    end

    if (cpu_ret) cpu_rdata_d = bus.mem_rdata;
    if (dma_ret) dma_rdata_d = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      owner_q      <= OWN_CPU;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      owner_q      <= owner_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model.
module tb_dmem_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;

  logic clk;
  logic rst;

  int total;
  int bad;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [9:0]    d_pat;
  logic [AW-1:0] pre_a [5];
  logic [DW-1:0] pre_d [5];

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, one-cycle read latency.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
  endtask

  // Advance to just after the next rising edge; inputs are then applied and
  // outputs checked mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    bus.mem_rdata = '0;
    set_cpu(1'b1, 1'b0, 14'h0010, 32'h0);
    set_dma(1'b1, 1'b1, 14'h0020, 32'h5555AAAA);

    pre_a[0] = 14'h0010; pre_d[0] = 32'hDEADBEEF;
    pre_a[1] = 14'h0001; pre_d[1] = 32'h11111111;
    pre_a[2] = 14'h0002; pre_d[2] = 32'h22222222;
    pre_a[3] = 14'h0020; pre_d[3] = 32'hA0A0A0A0;
    pre_a[4] = 14'h0030; pre_d[4] = 32'hB0B0B0B0;

    // Reset with both requesters active while the memory is preloaded.
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      pre_en = 1'b1; pre_addr = pre_a[i]; pre_data = pre_d[i];
    end
    next_cycle();
    pre_en = 1'b0;
    #1;
    chk("rst_cpu_grant", bus.cpu_grant, 0);
    chk("rst_dma_grant", bus.dma_grant, 0);
    chk("rst_mem_en",    bus.mem_en, 0);
    chk("rst_mem_we",    bus.mem_we, 0);
    chk("rst_cpu_stall", bus.cpu_stall, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_dma_rvalid", bus.dma_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dma_rdata", bus.dma_rdata, 0);
    chk("rst_starve",    dut.starve_cnt_q, 0);

    // CPU read of 0x0010 in the first cycle after reset.
    next_cycle();
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 14'h0010, 32'h0);
    set_dma(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("rd_cpu_grant", bus.cpu_grant, 1);
    chk("rd_cpu_stall", bus.cpu_stall, 0);
    chk("rd_mem_en",    bus.mem_en, 1);
    chk("rd_mem_we",    bus.mem_we, 0);
    chk("rd_mem_addr",  bus.mem_addr, 32'h0010);

    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
    chk("rd_dma_rvalid", bus.dma_rvalid, 0);
    chk("rd_idle_mem_en", bus.mem_en, 0);

    next_cycle();
    #1;
    chk("rd_hold_rvalid", bus.cpu_rvalid, 0);
    chk("rd_hold_rdata",  bus.cpu_rdata, 32'hDEADBEEF);

    // Continuous contention: DMA wins every fifth cycle.
    d_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      set_cpu(1'b1, 1'b0, 14'h0020, 32'h0);
      set_dma(1'b1, 1'b0, 14'h0030, 32'h0);
      #1;
      chk($sformatf("cont%0d_cpu_grant", i), bus.cpu_grant, {31'd0, ~d_pat[i]});
      chk($sformatf("cont%0d_dma_grant", i), bus.dma_grant, {31'd0, d_pat[i]});
      chk($sformatf("cont%0d_cpu_stall", i), bus.cpu_stall, {31'd0, d_pat[i]});
      chk($sformatf("cont%0d_starve", i), dut.starve_cnt_q, i % 5);
      if (i > 0) begin
        chk($sformatf("cont%0d_cpu_rvalid", i), bus.cpu_rvalid, {31'd0, ~d_pat[i-1]});
        chk($sformatf("cont%0d_dma_rvalid", i), bus.dma_rvalid, {31'd0, d_pat[i-1]});
        if (d_pat[i-1]) chk($sformatf("cont%0d_dma_rdata", i), bus.dma_rdata, 32'hB0B0B0B0);
        else            chk($sformatf("cont%0d_cpu_rdata", i), bus.cpu_rdata, 32'hA0A0A0A0);
      end
    end

    // Interleaved returns: CPU read 0x0001 then DMA read 0x0002.
    next_cycle();
    set_cpu(1'b1, 1'b0, 14'h0001, 32'h0);
    set_dma(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("il_a_cpu_grant", bus.cpu_grant, 1);
    chk("il_a_dma_rvalid", bus.dma_rvalid, 1);
    chk("il_a_dma_rdata", bus.dma_rdata, 32'hB0B0B0B0);
    chk("il_a_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("il_a_starve", dut.starve_cnt_q, 0);

    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 32'h0);
    set_dma(1'b1, 1'b0, 14'h0002, 32'h0);
    #1;
    chk("il_b_dma_grant", bus.dma_grant, 1);
    chk("il_b_cpu_grant", bus.cpu_grant, 0);
    chk("il_b_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("il_b_cpu_rdata", bus.cpu_rdata, 32'h11111111);
    chk("il_b_dma_rvalid", bus.dma_rvalid, 0);

    next_cycle();
    set_dma(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("il_c_dma_rvalid", bus.dma_rvalid, 1);
    chk("il_c_dma_rdata", bus.dma_rdata, 32'h22222222);
    chk("il_c_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("il_c_cpu_rdata", bus.cpu_rdata, 32'h11111111);

    // DMA alone: granted every cycle, counter stays clear.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_dma(1'b1, 1'b0, 14'h0030, 32'h0);
      #1;
      chk($sformatf("dmaonly%0d_grant", i), bus.dma_grant, 1);
      chk($sformatf("dmaonly%0d_starve", i), dut.starve_cnt_q, 0);
    end

    // DMA write 0x12345678 to 0x0100, then CPU reads it back.
    next_cycle();
    set_dma(1'b1, 1'b1, 14'h0100, 32'h12345678);
    #1;
    chk("wr_dma_grant", bus.dma_grant, 1);
    chk("wr_mem_we",    bus.mem_we, 1);
    chk("wr_mem_addr",  bus.mem_addr, 32'h0100);
    chk("wr_mem_wdata", bus.mem_wdata, 32'h12345678);

    next_cycle();
    set_dma(1'b0, 1'b0, 14'h0, 32'h0);
    set_cpu(1'b1, 1'b0, 14'h0100, 32'h0);
    #1;
    chk("wr_rd_cpu_grant", bus.cpu_grant, 1);
    chk("wr_rd_mem_we",    bus.mem_we, 0);
    chk("wr_no_dma_rvalid", bus.dma_rvalid, 0);
    chk("wr_no_cpu_rvalid", bus.cpu_rvalid, 0);

    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("wr_ret_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("wr_ret_cpu_rdata",  bus.cpu_rdata, 32'h12345678);
    chk("wr_ret_mem_we",     bus.mem_we, 0);

    // Reset right after a granted CPU read.
    next_cycle();
    set_cpu(1'b1, 1'b0, 14'h0010, 32'h0);
    #1;
    chk("mr_cpu_grant", bus.cpu_grant, 1);

    next_cycle();
    rst = 1'b1;
    set_dma(1'b1, 1'b1, 14'h0030, 32'h0);
    #1;
    chk("mr_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("mr_dma_rvalid", bus.dma_rvalid, 0);
    chk("mr_cpu_grant0", bus.cpu_grant, 0);
    chk("mr_dma_grant0", bus.dma_grant, 0);
    chk("mr_mem_en",     bus.mem_en, 0);
    chk("mr_mem_we",     bus.mem_we, 0);
    chk("mr_cpu_stall",  bus.cpu_stall, 0);

    next_cycle();
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 14'h0020, 32'h0);
    set_dma(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("post_cpu_grant", bus.cpu_grant, 1);
    chk("post_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("post_starve",     dut.starve_cnt_q, 0);
    chk("post_cpu_rdata",  bus.cpu_rdata, 0);
    chk("post_dma_rdata",  bus.dma_rdata, 0);

    next_cycle();
    set_cpu(1'b0, 1'b0, 14'h0, 32'h0);
    #1;
    chk("post_ret_rvalid", bus.cpu_rvalid, 1);
    chk("post_ret_rdata",  bus.cpu_rdata, 32'hA0A0A0A0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 14, word-address width of the shared data memory.
REQ-002 Parameter: DATA_W, default 32, data word width.
REQ-003 Parameter: STARVE_LIM, default 4, number of consecutive denied DMA cycles after which DMA wins one grant.
REQ-004 Port list (name, direction, width, meaning). The block SHALL have one clock (clk); rst SHALL be synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU MEM-stage access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_grant  out  1  CPU access issued this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_grant; freezes the pipeline.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  cpu_rdata valid, one cycle.
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meanings for the sprite/OAM DMA requester.
- dma_grant  out  1  DMA access issued this cycle.
- dma_rdata  out  DATA_W  DMA read data.
- dma_rvalid  out  1  dma_rdata valid, one cycle.
- mem_en, mem_we  out  1/1  memory enable and write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, one-cycle latency.

Function
REQ-005 At most one of cpu_grant and dma_grant SHALL be high in any cycle; mem_en SHALL equal cpu_grant | dma_grant.
REQ-006 Grants SHALL be combinational from the requests and registered state; the winning requester's addr, we and wdata SHALL drive mem_* in the grant cycle. With no grant, mem_we = 0.
REQ-007 Default priority: CPU over DMA.
REQ-008 starve_cnt SHALL increment, saturating at STARVE_LIM, each cycle in which dma_req = 1 and dma_grant = 0. It SHALL clear on dma_grant.
REQ-009 When starve_cnt == STARVE_LIM and dma_req = 1, DMA SHALL win that cycle even if cpu_req = 1.
REQ-010 The requester SHALL hold req and its payload stable until granted. The arbiter SHALL NOT latch a request that is withdrawn before grant.
REQ-011 Read return: a 1-bit owner tag and a rd_pend flag SHALL be registered in the grant cycle of a read. In the following cycle, mem_rdata SHALL be routed to the tagged requester's rdata, with that requester's rvalid = 1 for exactly one cycle.
REQ-012 Writes SHALL produce no rvalid.
REQ-013 Back-to-back grants SHALL be allowed every cycle, giving a throughput of one access per cycle. A read's rvalid SHALL coincide with the next grant without conflict.
REQ-014 cpu_rdata and dma_rdata SHALL hold their last valid value when the corresponding rvalid = 0.
REQ-015 Simultaneous requests with starve_cnt < STARVE_LIM: CPU is granted, DMA stalls, and starve_cnt increments.
REQ-016 Only DMA requesting: DMA is granted every cycle and starve_cnt stays 0.

Reset
REQ-017 While rst = 1: all grants = 0, mem_en = 0, mem_we = 0, cpu_stall = 0, both rvalid = 0, starve_cnt = 0, rd_pend = 0, owner tag = CPU, and rdata registers = 0.
REQ-018 A read granted in the cycle that rst asserts SHALL NOT produce rvalid after reset.
REQ-019 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-020 A shared package SHALL hold the ADDR_W/DATA_W defaults and the owner encoding (OWN_CPU = 0, OWN_DMA = 1), for reuse by MEM_Unit and the DMA engine.
REQ-021 No sub-module is required; the arbitration logic, starvation counter and return router SHALL be a single module.

Verification
REQ-022 CPU read only: cpu_req = 1, addr 0x0010, memory holds 0xDEADBEEF. Required: cpu_grant same cycle, cpu_stall = 0, next cycle cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF, dma_rvalid = 0.
REQ-023 Continuous contention with STARVE_LIM = 4: cpu_req and dma_req both held 1 for 10 cycles. Required: grant pattern C,C,C,C,D,C,C,C,C,D, and cpu_stall = 1 exactly in the two DMA-grant cycles.
REQ-024 Interleaved returns: CPU read 0x0001, then a DMA read of 0x0002 on the next cycle. Required: cpu_rvalid in cycle +1 and dma_rvalid in cycle +2, each with the correct word and never both high at once.
REQ-025 Write then read: DMA writes 0x12345678 to 0x0100, then the CPU reads 0x0100. Required: mem_we = 1 only in the write cycle, no rvalid for the write, and cpu_rdata = 0x12345678.
REQ-026 Reset mid-operation: a CPU read is granted, and rst = 1 the next cycle. Required: cpu_rvalid = 0, all outputs at their reset values, starve_cnt = 0, and a normal grant in the first post-reset cycle.
